// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I datapath: opcodes, controller
// states, ALU function codes and datapath mux select values.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_JALR_ADR,
        S_ILLEGAL
    } mc_state_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b1000;

    localparam logic [SEL_W-1:0] SRC_A_PC    = 2'd0;
    localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [SEL_W-1:0] SRC_A_RS1   = 2'd2;

    localparam logic [SEL_W-1:0] SRC_B_RS2   = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B_IMM   = 2'd1;
    localparam logic [SEL_W-1:0] SRC_B_FOUR  = 2'd2;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'd0;
    localparam logic [SEL_W-1:0] RES_MEM     = 2'd1;
    localparam logic [SEL_W-1:0] RES_ALU     = 2'd2;

    // First state after DECODE for a given opcode.
    function automatic mc_state_t decode_target(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE: return S_MEM_ADR;
            OP_REG:            return S_EXEC_R;
            OP_IMM:            return S_EXEC_I;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JUMP;
            OP_JALR:           return S_JALR_ADR;
            default:           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multicycle RV32I datapath: steps each
// instruction through fetch/decode/execute/memory/writeback states.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [2:0]          funct3_i,
    input  logic [6:0]          funct7_i,
    input  logic                branch_taken_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                adr_src_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                reg_write_o,
    output logic [SEL_W-1:0]    alu_src_a_o,
    output logic [SEL_W-1:0]    alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [SEL_W-1:0]    result_src_o,
    output logic                instr_retired_o,
    output logic                illegal_o
);

    mc_state_t state_q, state_d;

    // Only funct7[5] selects SUB/SRA; the remaining bits are immediate/reserved.
    logic funct7_unused;
    assign funct7_unused = ^{funct7_i[6], funct7_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        adr_src_o       = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = SRC_A_PC;
        alu_src_b_o     = SRC_B_RS2;
        alu_op_o        = ALU_ADD;
        result_src_o    = RES_ALUOUT;
        instr_retired_o = 1'b0;
        illegal_o       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_a_o  = SRC_A_PC;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            // ALUOut captures oldPC+imm as the branch/JAL target.
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                state_d     = decode_target(opcode_i);
            end
            S_MEM_ADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                mem_req_o       = 1'b1;
                mem_we_o        = 1'b1;
                adr_src_o       = 1'b1;
                instr_retired_o = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write_o     = 1'b1;
                result_src_o    = RES_MEM;
                instr_retired_o = 1'b1;
                state_d         = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_op_o    = {funct7_i[5], funct3_i};
                state_d     = S_ALU_WB;
            end
            // funct7[5] is an immediate bit except for SRAI, so ADDI never becomes SUB.
            S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = (funct3_i == 3'b101) ? {funct7_i[5], funct3_i}
                                                   : {1'b0, funct3_i};
                state_d     = S_ALU_WB;
            end
            S_BRANCH: begin
                alu_src_a_o     = SRC_A_RS1;
                alu_src_b_o     = SRC_B_RS2;
                alu_op_o        = ALU_SUB;
                result_src_o    = RES_ALUOUT;
                pc_write_o      = branch_taken_i;
                instr_retired_o = 1'b1;
                state_d         = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = S_JUMP;
            end
            // PC takes the target from ALUOut while the ALU forms the link oldPC+4.
            S_JUMP: begin
                pc_write_o   = 1'b1;
                result_src_o = RES_ALUOUT;
                alu_src_a_o  = SRC_A_OLDPC;
                alu_src_b_o  = SRC_B_FOUR;
                state_d      = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o     = 1'b1;
                result_src_o    = RES_ALUOUT;
                instr_retired_o = 1'b1;
                state_d         = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset and
// illegal-opcode sequences, then randomized instructions against a cycle-count model.
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op;
    logic       instr_retired, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .opcode_i        (opcode),
        .funct3_i        (funct3),
        .funct7_i        (funct7),
        .branch_taken_i  (branch_taken),
        .mem_ready_i     (mem_ready),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .adr_src_o       (adr_src),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .result_src_o    (result_src),
        .instr_retired_o (instr_retired),
        .illegal_o       (illegal)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        bt;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Output vector: mem_req,mem_we,adr_src,ir_write,pc_write,reg_write,a,b,op,res,retired,illegal
    function automatic logic [17:0] ov(input logic mreq, input logic mwe, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] op, input logic [1:0] rs,
                                       input logic ret, input logic ill);
        return {mreq, mwe, adr, irw, pcw, rw, a, b, op, rs, ret, ill};
    endfunction

    function automatic logic [17:0] outs();
        return {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal};
    endfunction

    function automatic logic [17:0] o_fetch(input logic r);
        return ov(1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'd0, 2'd2, 4'd0, 2'd2, 1'b0, 1'b0);
    endfunction

    logic [17:0] o_dec, o_adr, o_rd, o_wr, o_memwb, o_aluwb, o_jump, o_ill;

    task automatic add(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bt, input logic rdy,
                       input logic [17:0] exp);
        vec_t v;
        v.rst = rst; v.opc = opc; v.f3 = f3; v.f7 = f7; v.bt = bt; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, step past the next edge.
    task automatic cyc(input string tag, input int idx, input logic rst, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7, input logic bt,
                       input logic rdy, input logic [17:0] exp);
        reset = rst; opcode = opc; funct3 = f3; funct7 = f7; branch_taken = bt; mem_ready = rdy;
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: outputs got %05h expected %05h", tag, idx, outs(), exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        o_dec   = ov(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 2'd0, 0, 0);
        o_adr   = ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0, 0);
        o_rd    = ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0);
        o_wr    = ov(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0);
        o_memwb = ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 2'd1, 1, 0);
        o_aluwb = ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0);
        o_jump  = ov(0, 0, 0, 0, 1, 0, 2'd1, 2'd2, 4'd0, 2'd0, 0, 0);
        o_ill   = ov(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 1);
        @(posedge clk);
        #1;

        // ADDI x1,x0,5 (IR 0x00500093), reset held in the first FETCH cycle
        add(1, OPC_IMM, 3'b000, 7'h00, 0, 0, o_fetch(0));
        add(0, OPC_IMM, 3'b000, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_IMM, 3'b000, 7'h00, 0, 0, o_dec);
        add(0, OPC_IMM, 3'b000, 7'h00, 0, 1, ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'b0000, 2'd0, 0, 0));
        add(0, OPC_IMM, 3'b000, 7'h00, 0, 0, o_aluwb);
        // LW with three MEM_RD wait cycles
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 1, o_dec);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 0, o_adr);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 0, o_rd);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 0, o_rd);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 0, o_rd);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 1, o_rd);
        add(0, OPC_LOAD, 3'b010, 7'h00, 0, 0, o_memwb);
        // BEQ not taken, then taken
        add(0, OPC_BRANCH, 3'b000, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_BRANCH, 3'b000, 7'h00, 0, 1, o_dec);
        add(0, OPC_BRANCH, 3'b000, 7'h00, 0, 1, ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b1000, 2'd0, 1, 0));
        add(0, OPC_BRANCH, 3'b000, 7'h00, 1, 1, o_fetch(1));
        add(0, OPC_BRANCH, 3'b000, 7'h00, 1, 1, o_dec);
        add(0, OPC_BRANCH, 3'b000, 7'h00, 1, 1, ov(0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 4'b1000, 2'd0, 1, 0));
        // JALR
        add(0, OPC_JALR, 3'b000, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_JALR, 3'b000, 7'h00, 0, 1, o_dec);
        add(0, OPC_JALR, 3'b000, 7'h00, 0, 1, o_adr);
        add(0, OPC_JALR, 3'b000, 7'h00, 0, 1, o_jump);
        add(0, OPC_JALR, 3'b000, 7'h00, 0, 1, o_aluwb);
        // SUB after one fetch wait
        add(0, OPC_REG, 3'b000, 7'h20, 0, 0, o_fetch(0));
        add(0, OPC_REG, 3'b000, 7'h20, 0, 1, o_fetch(1));
        add(0, OPC_REG, 3'b000, 7'h20, 0, 0, o_dec);
        add(0, OPC_REG, 3'b000, 7'h20, 0, 0, ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b1000, 2'd0, 0, 0));
        add(0, OPC_REG, 3'b000, 7'h20, 0, 0, o_aluwb);
        // ADDI with funct7[5] set by the immediate stays ADD
        add(0, OPC_IMM, 3'b000, 7'h20, 0, 1, o_fetch(1));
        add(0, OPC_IMM, 3'b000, 7'h20, 0, 1, o_dec);
        add(0, OPC_IMM, 3'b000, 7'h20, 0, 1, ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'b0000, 2'd0, 0, 0));
        add(0, OPC_IMM, 3'b000, 7'h20, 0, 1, o_aluwb);
        // SRAI keeps funct7[5]
        add(0, OPC_IMM, 3'b101, 7'h20, 0, 1, o_fetch(1));
        add(0, OPC_IMM, 3'b101, 7'h20, 0, 1, o_dec);
        add(0, OPC_IMM, 3'b101, 7'h20, 0, 1, ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'b1101, 2'd0, 0, 0));
        add(0, OPC_IMM, 3'b101, 7'h20, 0, 1, o_aluwb);
        // SW zero-wait
        add(0, OPC_STORE, 3'b010, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_STORE, 3'b010, 7'h00, 0, 1, o_dec);
        add(0, OPC_STORE, 3'b010, 7'h00, 0, 1, o_adr);
        add(0, OPC_STORE, 3'b010, 7'h00, 0, 1, ov(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0));
        // JAL
        add(0, OPC_JAL, 3'b000, 7'h00, 0, 1, o_fetch(1));
        add(0, OPC_JAL, 3'b000, 7'h00, 0, 0, o_dec);
        add(0, OPC_JAL, 3'b000, 7'h00, 0, 0, o_jump);
        add(0, OPC_JAL, 3'b000, 7'h00, 0, 0, o_aluwb);
        add(0, OPC_JAL, 3'b000, 7'h00, 0, 0, o_fetch(0));

        foreach (tbl[i]) cyc("vec", i, tbl[i].rst, tbl[i].opc, tbl[i].f3, tbl[i].f7,
                             tbl[i].bt, tbl[i].rdy, tbl[i].exp);

        // Reset while MEM_WR waits: write stays visible that cycle, then abandoned
        cyc("rst_wr", 0, 0, OPC_STORE, 3'b010, 7'h00, 0, 1, o_fetch(1));
        cyc("rst_wr", 1, 0, OPC_STORE, 3'b010, 7'h00, 0, 1, o_dec);
        cyc("rst_wr", 2, 0, OPC_STORE, 3'b010, 7'h00, 0, 0, o_adr);
        cyc("rst_wr", 3, 1, OPC_STORE, 3'b010, 7'h00, 0, 0, o_wr);
        cyc("rst_wr", 4, 0, OPC_STORE, 3'b010, 7'h00, 0, 0, o_fetch(0));
        cyc("rst_wr", 5, 0, OPC_STORE, 3'b010, 7'h00, 0, 0, o_fetch(0));

        // Illegal opcode is sticky until reset
        cyc("ill", 0, 0, OPC_BAD, 3'b000, 7'h00, 0, 1, o_fetch(1));
        cyc("ill", 1, 0, OPC_BAD, 3'b000, 7'h00, 0, 1, o_dec);
        for (int i = 0; i < 10; i++)
            cyc("ill", 2 + i, 0, OPC_BAD, 3'b000, 7'h00, 1'(i), 1'(i), o_ill);
        cyc("ill", 12, 1, OPC_BAD, 3'b000, 7'h00, 0, 1, o_ill);
        cyc("ill", 13, 0, OPC_BAD, 3'b000, 7'h00, 0, 0, o_fetch(0));

        // Randomized instructions against counts derived from the latency rules
        for (int n = 0; n < 200; n++) begin
            int k, fw, mw, fl, dl, base;
            int n_cyc, n_ret, n_rw, n_pcw, n_we, n_req, n_irw, n_ill;
            int exp_cyc, exp_rw, exp_pcw, exp_we, exp_req;
            logic [6:0] opc, f7;
            logic [2:0] f3;
            logic [3:0] op_seen, exp_op;
            logic bt, done, ld;
            k  = $urandom_range(0, 6);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            bt = 1'($urandom_range(0, 1));
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            fl = fw; dl = mw;
            case (k)
                0:       begin opc = OPC_REG;    base = 4; end
                1:       begin opc = OPC_IMM;    base = 4; end
                2:       begin opc = OPC_LOAD;   base = 5; end
                3:       begin opc = OPC_STORE;  base = 4; end
                4:       begin opc = OPC_BRANCH; base = 3; end
                5:       begin opc = OPC_JAL;    base = 4; end
                default: begin opc = OPC_JALR;   base = 5; end
            endcase
            ld      = (k == 2) || (k == 3);
            exp_cyc = base + fw + (ld ? mw : 0);
            exp_req = fw + 1 + (ld ? mw + 1 : 0);
            exp_we  = (k == 3) ? mw + 1 : 0;
            exp_rw  = (k == 3 || k == 4) ? 0 : 1;
            exp_pcw = 1 + ((k == 4 && bt) ? 1 : 0) + ((k == 5 || k == 6) ? 1 : 0);
            exp_op  = (k == 0 || f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
            n_cyc = 0; n_ret = 0; n_rw = 0; n_pcw = 0; n_we = 0; n_req = 0; n_irw = 0; n_ill = 0;
            op_seen = 4'hF;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                reset = 1'b0; opcode = opc; funct3 = f3; funct7 = f7; branch_taken = bt;
                if (mem_req && !adr_src) begin
                    mem_ready = (fl == 0);
                    if (fl > 0) fl--;
                end else if (mem_req) begin
                    mem_ready = (dl == 0);
                    if (dl > 0) dl--;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                n_cyc++;
                n_ret += int'(instr_retired);
                n_rw  += int'(reg_write);
                n_pcw += int'(pc_write);
                n_we  += int'(mem_we);
                n_req += int'(mem_req);
                n_irw += int'(ir_write);
                n_ill += int'(illegal);
                if (alu_src_a == 2'd2) op_seen = alu_op;
                done = instr_retired;
                @(posedge clk);
                #1;
            end
            chk($sformatf("rnd%0d k%0d cycles", n, k), n_cyc, exp_cyc);
            chk($sformatf("rnd%0d k%0d retired", n, k), n_ret, 1);
            chk($sformatf("rnd%0d k%0d reg_write", n, k), n_rw, exp_rw);
            chk($sformatf("rnd%0d k%0d pc_write", n, k), n_pcw, exp_pcw);
            chk($sformatf("rnd%0d k%0d mem_we", n, k), n_we, exp_we);
            chk($sformatf("rnd%0d k%0d mem_req", n, k), n_req, exp_req);
            chk($sformatf("rnd%0d k%0d ir_write", n, k), n_irw, 1);
            chk($sformatf("rnd%0d k%0d illegal", n, k), n_ill, 0);
            if (k <= 1) chk($sformatf("rnd%0d k%0d alu_op", n, k), int'(op_seen), int'(exp_op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle RV32I datapath. It replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. Per-state mux selects and enables drive a shared ALU, one unified memory port with a ready handshake, and the register file. It sits between the instruction register and the datapath muxes.

## Interface
Parameters:
- none; encodings come from the shared package.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  IR[6:0], valid from DECODE onward.
- `funct3`  in  3  IR[14:12].
- `funct7`  in  7  IR[31:25].
- `branch_taken`  in  1  datapath comparator result for the current funct3.
- `mem_ready`  in  1  memory completes the access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier, valid with `mem_req`.
- `adr_src`  out  1  memory address: 0=PC, 1=ALUOut.
- `ir_write`  out  1  latch IR and oldPC.
- `pc_write`  out  1  load PC from result bus.
- `reg_write`  out  1  register-file write of result bus to rd.
- `alu_src_a`  out  2  0=PC, 1=oldPC, 2=rs1.
- `alu_src_b`  out  2  0=rs2, 1=imm, 2=const 4.
- `alu_op`  out  4  ALU function code.
- `result_src`  out  2  0=ALUOut, 1=mem data, 2=ALU result.
- `instr_retired`  out  1  one-cycle pulse in each instruction's final state.
- `illegal`  out  1  sticky; unsupported opcode seen.

## Operation
States and transitions:
- FETCH → DECODE on `mem_ready`.
- DECODE → one of the following by opcode:
  - MEM_ADR for 0000011 or 0100011.
  - EXEC_R for 0110011.
  - EXEC_I for 0010011.
  - BRANCH for 1100011.
  - JUMP for 1101111.
  - JALR_ADR for 1100111.
  - ILLEGAL for any other opcode.
- MEM_ADR → MEM_RD for loads, MEM_WR for stores.
- MEM_RD → MEM_WB on `mem_ready`.
- MEM_WR → FETCH on `mem_ready`.
- EXEC_R and EXEC_I → ALU_WB.
- JALR_ADR → JUMP.
- JUMP → ALU_WB.
- ALU_WB, MEM_WB and BRANCH → FETCH.
- ILLEGAL → ILLEGAL until `reset`.

Per-state outputs (anything unlisted is 0):
- FETCH: `mem_req`, `adr_src`=0, `alu_src_a`=0, `alu_src_b`=2, `alu_op`=ADD, `result_src`=2. `ir_write` and `pc_write` equal `mem_ready`.
- DECODE: `alu_src_a`=1, `alu_src_b`=1, ADD. ALUOut becomes the branch/JAL target.
- MEM_ADR and JALR_ADR: `alu_src_a`=2, `alu_src_b`=1, ADD.
- MEM_RD: `mem_req`, `adr_src`=1.
- MEM_WR: `mem_req`, `mem_we`, `adr_src`=1, `instr_retired`=`mem_ready`.
- MEM_WB: `reg_write`, `result_src`=1, `instr_retired`.
- EXEC_R: `alu_src_a`=2, `alu_src_b`=0, `alu_op`={funct7[5],funct3}.
- EXEC_I: `alu_src_a`=2, `alu_src_b`=1. `alu_op`={funct7[5],funct3} when funct3=101, otherwise {0,funct3}, so ADDI is never decoded as SUB.
- BRANCH: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=SUB, `result_src`=0, `pc_write`=`branch_taken`, `instr_retired`.
- JUMP: `pc_write`, `result_src`=0, `alu_src_a`=1, `alu_src_b`=2, ADD. This computes link = oldPC+4. The datapath clears bit 0 of the target for JALR.
- ALU_WB: `reg_write`, `result_src`=0, `instr_retired`.
- ILLEGAL: `illegal`=1. No enables are asserted.

## Timing
- Reset: state is FETCH on the first edge with `reset`=1. In that same cycle `illegal`=0, `mem_req`=1, and `ir_write`/`pc_write` follow `mem_ready`.
- Reset mid-instruction: the state is abandoned and no further enables issue. A write already asserted in that cycle is not suppressed.
- Memory handshake:
  - `mem_req`, `mem_we` and `adr_src` are held stable until the cycle in which `mem_ready`=1.
  - The state advances on that edge.
  - `mem_ready` outside a request state is ignored.
  - A zero-wait memory (`mem_ready` tied high) gives one cycle per memory state.
- Latency with zero-wait memory: R/I 4, load 5, store 4, branch 3, JAL 4, JALR 5 cycles.
- Each wait cycle adds exactly 1 cycle to that count.
- `instr_retired` pulses exactly once per completed instruction and never in ILLEGAL.
- `opcode`, `funct3` and `funct7` are sampled only from DECODE onward; IR is stable by then.

## Structure
- `riscv_pkg` holds:
  - the opcode constants;
  - the `mc_state_t` enum (13 states, 4 bits);
  - the ALU op codes ADD=0000 and SUB=1000;
  - the localparams for the `alu_src_a`, `alu_src_b` and `result_src` encodings.
- Single module: state register plus combinational next-state and output blocks. No sub-module is needed.

## Test plan
- Reset, then `mem_ready`=1 with IR=0x00500093 (ADDI x1,x0,5): states FETCH, DECODE, EXEC_I, ALU_WB. `alu_op`=0000 in EXEC_I; `reg_write` and `instr_retired` high in cycle 4.
- LW with `mem_ready` low for 3 cycles in MEM_RD: `mem_req`=1 and `adr_src`=1 held for 4 cycles. `reg_write` only in MEM_WB; total 8 cycles.
- BEQ with `branch_taken`=0, then 1: `pc_write` 0, then 1 in BRANCH, `result_src`=0. Both take 3 cycles.
- JALR: JALR_ADR has `alu_src_a`=2 and `alu_src_b`=1. JUMP has `pc_write`=1. ALU_WB writes link; 5 cycles total.
- Opcode 0x7F: ILLEGAL, `illegal`=1 and stays through 10 cycles of `mem_ready` toggling. `reset` returns to FETCH with `illegal`=0.
- `reset` asserted in MEM_WR while `mem_ready`=0: next state is FETCH, `mem_we`=0, `instr_retired` never pulses.
